ulpb_tx_sched: RTL and testbench

Local transmit scheduler for a ULPB node. It shares the node's single bus transmitter among `NUM_REQ` on-chip requesters (layer controllers, DMA, etc.) using round-robin arbitration. It waits for the bus controller to report an idle bus, launches one transmission per grant, and retries after a fixed backoff when arbitration is lost or the frame is interrupted by a reset sequence. It sits between the requesters and the bus control/frame logic.

---
 rtl/ulpb_tx_sched_pkg.sv | 21 ++
 rtl/ulpb_tx_sched_rr_pick.sv | 27 ++
 rtl/ulpb_tx_sched.sv | 145 ++++++++++++++
 tb/tb_ulpb_tx_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_tx_sched_pkg.sv
// ulpb_tx_sched_pkg: shared state encodings and width helper for the ULPB transmit scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ulpb_tx_sched_pkg;

  typedef enum logic [2:0] {
    TXS_IDLE     = 3'd0,
    TXS_WAIT_BUS = 3'd1,
    TXS_XFER     = 3'd2,
    TXS_BACKOFF  = 3'd3
  } txs_state_t;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ulpb_tx_sched_rr_pick.sv
// ulpb_rr_pick: round-robin picker; returns first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is pending.
// Ports: REQ (request vector), ptr (priority pointer) -> sel (picked index), any (some request set).
module ulpb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               any
);

  always_comb begin
    sel = ptr;
    any = |REQ;
    // Walk offsets from highest to lowest so the smallest offset from ptr wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (REQ[idx]) sel = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/ulpb_tx_sched.sv
// ulpb_tx_sched: round-robin scheduler sharing one bus transmitter among NUM_REQ requesters.
// Latency: grant 1 cycle after REQ in IDLE; TX_START 1 cycle after BUS_IDLE in WAIT_BUS; all outputs registered.
// Backpressure: waits on BUS_IDLE before launching; retries after BACKOFF_CYCLES on FAIL, drops after MAX_RETRY.
// Ports: CLK/RESET (async active-high); REQ, BUS_IDLE, DONE, FAIL in; GNT, TX_START, ERR, BUSY, test_pt out.
module ulpb_tx_sched
  import ulpb_tx_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BACKOFF_CYCLES = 8,
  parameter int MAX_RETRY      = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               BUS_IDLE,
  input  logic               DONE,
  input  logic               FAIL,
  output logic [NUM_REQ-1:0] GNT,
  output logic               TX_START,
  output logic [NUM_REQ-1:0] ERR,
  output logic               BUSY,
  output logic [2:0]         test_pt
);

  localparam int PTR_W = log2(NUM_REQ);
  localparam int RTY_W = log2(MAX_RETRY + 1);
  localparam int BO_W  = log2(BACKOFF_CYCLES);

  txs_state_t         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [BO_W-1:0]    bo_q, bo_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q;

  logic [PTR_W-1:0]   pick_sel;
  logic               pick_any;
  logic [PTR_W-1:0]   ptr_after_sel;
  logic [RTY_W-1:0]   retry_inc;

  ulpb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .REQ (REQ),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester.
  assign ptr_after_sel = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign retry_inc     = retry_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    retry_d    = retry_q;
    bo_d       = bo_q;
    gnt_d      = gnt_q;
    err_d      = '0;
    tx_start_d = 1'b0;
    unique case (state_q)
      TXS_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_sel;
          gnt_d   = NUM_REQ'(1) << pick_sel;
          retry_d = '0;
          state_d = TXS_WAIT_BUS;
        end
      end
      TXS_WAIT_BUS: begin
        // Withdrawal beats a ready bus; pointer stays so the same requester keeps priority.
        if (!REQ[sel_q]) begin
          gnt_d   = '0;
          state_d = TXS_IDLE;
        end else if (BUS_IDLE) begin
          tx_start_d = 1'b1;
          state_d    = TXS_XFER;
        end
      end
      TXS_XFER: begin
        if (DONE) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_sel;
          state_d = TXS_IDLE;
        end else if (FAIL) begin
          retry_d = retry_inc;
          if (retry_inc == RTY_W'(MAX_RETRY)) begin
            err_d   = NUM_REQ'(1) << sel_q;
            gnt_d   = '0;
            ptr_d   = ptr_after_sel;
            state_d = TXS_IDLE;
          end else begin
            bo_d    = BO_W'(BACKOFF_CYCLES - 1);
            state_d = TXS_BACKOFF;
          end
        end
      end
      TXS_BACKOFF: begin
        if (bo_q != '0) bo_d = bo_q - 1'b1;
        else            state_d = TXS_WAIT_BUS;
      end
      default: begin
        gnt_d   = '0;
        state_d = TXS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= TXS_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      retry_q    <= '0;
      bo_q       <= '0;
      gnt_q      <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      retry_q    <= retry_d;
      bo_q       <= bo_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      busy_q     <= (state_d != TXS_IDLE);
    end
  end

  assign GNT      = gnt_q;
  assign ERR      = err_q;
  assign TX_START = tx_start_q;
  assign BUSY     = busy_q;
  assign test_pt  = state_q;

endmodule

// File: tb/tb_ulpb_tx_sched.sv
module tb_ulpb_tx_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       bus_idle;
  logic       done_in;
  logic       fail_in;
  logic [3:0] gnt;
  logic       tx_start;
  logic [3:0] err;
  logic       busy;
  logic [2:0] st;

  int tests;
  int fails;
  int tx_seen;
  int err_seen;

  ulpb_tx_sched #(
    .NUM_REQ        (4),
    .BACKOFF_CYCLES (8),
    .MAX_RETRY      (3)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .REQ      (req),
    .BUS_IDLE (bus_idle),
    .DONE     (done_in),
    .FAIL     (fail_in),
    .GNT      (gnt),
    .TX_START (tx_start),
    .ERR      (err),
    .BUSY     (busy),
    .test_pt  (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       bi;
    logic       done;
    logic       fail;
    logic [3:0] gnt;
    logic       tx;
    logic [3:0] err;
    logic       busy;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[40];
  int   nvec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic b, input logic d, input logic f);
    req      = r;
    bus_idle = b;
    done_in  = d;
    fail_in  = f;
    @(posedge clk);
    #1;
    if (tx_start) tx_seen++;
    if (err != 4'b0) err_seen++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},  32'(gnt), 32'h0);
    check({tag, ".tx"},   32'(tx_start), 32'h0);
    check({tag, ".err"},  32'(err), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".st"},   32'(st), 32'h0);
  endtask

  task automatic add(input logic [3:0] r, input logic b, input logic d, input logic f,
                     input logic [3:0] g, input logic tx, input logic [3:0] e,
                     input logic bz, input logic [2:0] s);
    vecs[nvec] = '{r, b, d, f, g, tx, e, bz, s};
    nvec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0; fails = 0; tx_seen = 0; err_seen = 0; nvec = 0;

    // Directed table: basic grant, pointer advance, round robin, DONE+FAIL, withdrawal.
    add(4'b0010, 0, 0, 0, 4'b0010, 0, 4'b0, 1, 3'd1);
    add(4'b0010, 1, 0, 0, 4'b0010, 1, 4'b0, 1, 3'd2);
    add(4'b0010, 1, 0, 0, 4'b0010, 0, 4'b0, 1, 3'd2);
    add(4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0, 0, 3'd0);   // ptr -> 2
    add(4'b0101, 0, 0, 0, 4'b0100, 0, 4'b0, 1, 3'd1);   // ptr=2 beats bit 0
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 4'b0, 1, 3'd2);
    add(4'b0101, 0, 1, 0, 4'b0000, 0, 4'b0, 0, 3'd0);   // ptr -> 3
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      g = 4'b0001 << ((3 + k) % 4);                      // order 3,0,1,2,3
      add(4'b1111, 1, 0, 0, g,       0, 4'b0, 1, 3'd1);
      add(4'b1111, 1, 0, 0, g,       1, 4'b0, 1, 3'd2);
      add(4'b1111, 0, 1, 0, 4'b0000, 0, 4'b0, 0, 3'd0);
    end
    add(4'b0001, 0, 0, 0, 4'b0001, 0, 4'b0, 1, 3'd1);
    add(4'b0001, 1, 0, 0, 4'b0001, 1, 4'b0, 1, 3'd2);
    add(4'b0000, 0, 1, 1, 4'b0000, 0, 4'b0, 0, 3'd0);   // DONE wins, ptr -> 1
    add(4'b0010, 0, 0, 0, 4'b0010, 0, 4'b0, 1, 3'd1);
    add(4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0, 0, 3'd0);   // withdraw beats BUS_IDLE
    add(4'b1110, 0, 0, 0, 4'b0010, 0, 4'b0, 1, 3'd1);   // ptr still 1
    add(4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0, 0, 3'd0);

    // Reset state.
    rst = 1'b1; req = '0; bus_idle = 1'b0; done_in = 1'b0; fail_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].req, vecs[i].bi, vecs[i].done, vecs[i].fail);
      check($sformatf("row%0d.gnt", i),  32'(gnt),      32'(vecs[i].gnt));
      check($sformatf("row%0d.tx", i),   32'(tx_start), 32'(vecs[i].tx));
      check($sformatf("row%0d.err", i),  32'(err),      32'(vecs[i].err));
      check($sformatf("row%0d.busy", i), 32'(busy),     32'(vecs[i].busy));
      check($sformatf("row%0d.st", i),   32'(st),       32'(vecs[i].st));
    end

    // Retry/backoff: FAIL, FAIL, DONE on requester 1 (ptr=1).
    tx_seen = 0; err_seen = 0;
    step(4'b0010, 0, 0, 0);
    check("rty.gnt", 32'(gnt), 32'h2);
    for (int a = 0; a < 3; a++) begin
      step(4'b0010, 1, 0, 0);
      check($sformatf("rty%0d.xfer", a), 32'(st), 32'd2);
      if (a < 2) begin
        step(4'b0010, 0, 0, 1);
        check($sformatf("rty%0d.bo_gnt", a), 32'(gnt), 32'h2);
        n = (st == 3'd3) ? 1 : 0;
        while (st == 3'd3 && n < 30) begin
          step(4'b0010, 0, 0, 0);
          if (st == 3'd3) n++;
        end
        check($sformatf("rty%0d.bo_len", a), 32'(n), 32'd8);
        check($sformatf("rty%0d.wait", a), 32'(st), 32'd1);
      end else begin
        step(4'b0010, 0, 1, 0);
        check("rty.done_st", 32'(st), 32'd0);
        check("rty.done_gnt", 32'(gnt), 32'h0);
      end
    end
    check("rty.tx_pulses", 32'(tx_seen), 32'd3);
    check("rty.no_err", 32'(err_seen), 32'd0);

    // Drop: three failures on requester 1 (ptr=2 wraps to 1).
    tx_seen = 0;
    step(4'b0010, 0, 0, 0);
    check("drop.gnt", 32'(gnt), 32'h2);
    for (int a = 0; a < 3; a++) begin
      step(4'b0010, 1, 0, 0);
      step(4'b0010, 0, 0, 1);
      if (a < 2) begin
        check($sformatf("drop%0d.err", a), 32'(err), 32'h0);
        n = 0;
        while (st != 3'd1 && n < 30) begin
          step(4'b0010, 0, 0, 0);
          n++;
        end
      end
    end
    check("drop.err", 32'(err), 32'h2);
    check("drop.gnt0", 32'(gnt), 32'h0);
    check("drop.st", 32'(st), 32'd0);
    check("drop.tx_pulses", 32'(tx_seen), 32'd3);
    step(4'b0110, 0, 0, 0);
    check("drop.err_pulse", 32'(err), 32'h0);
    check("drop.next_gnt", 32'(gnt), 32'h4);

    // Reset during XFER.
    step(4'b0110, 1, 0, 0);
    check("rx.xfer", 32'(st), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_xfer");
    @(negedge clk);
    rst = 1'b0;
    step(4'b1100, 0, 0, 0);
    check("rx.lowest", 32'(gnt), 32'h4);

    // Reset during BACKOFF.
    step(4'b1100, 1, 0, 0);
    step(4'b1100, 0, 0, 1);
    step(4'b1100, 0, 0, 0);
    step(4'b1100, 0, 0, 0);
    check("rb.backoff", 32'(st), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_bo");
    @(negedge clk);
    rst = 1'b0;
    step(4'b1010, 0, 0, 0);
    check("rb.lowest", 32'(gnt), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
